rx_hold_drain_ctrl: RTL
=======================

RX_HOLD_DRAIN_CTRL -- requirements
Module: rx_hold_drain_ctrl

Interface
REQ-001 Param MAX_FRAME_WORDS, default 1200: maximum forwarded words per frame before forced truncation.
REQ-002 Param EOPC_WIDTH, default 4: width of the pending-EOP counter.
REQ-003 clk_xgmii_rx  in  1  single clock; all logic on its rising edge.
REQ-004 reset_xgmii_rx  in  1  asynchronous, active-high reset.
REQ-005 rxhfifo_wen  in  1  hold-FIFO write strobe, snooped only.
REQ-006 rxhfifo_wstatus  in  8  hold-FIFO write status, snooped only.
REQ-007 rxhfifo_rdata  in  64  hold-FIFO read data, valid 1 cycle after rxhfifo_ren.
REQ-008 rxhfifo_rstatus  in  8  hold-FIFO read status, same timing as rdata.
REQ-009 rxhfifo_rempty  in  1  hold-FIFO empty.
REQ-010 rxhfifo_ralmost_empty  in  1  hold-FIFO almost empty.
REQ-011 rxhfifo_ren  out  1  hold-FIFO read enable.
REQ-012 rxdfifo_walmost_full  in  1  downstream data FIFO almost full; guarantees room for at least 2 further words.
REQ-013 rxdfifo_wen  out  1  downstream write strobe.
REQ-014 rxdfifo_wdata  out  64  downstream write data.
REQ-015 rxdfifo_wstatus  out  8  downstream write status.
REQ-016 frames_fwd  out  16  frames forwarded with EOP, saturating.
REQ-017 frames_drop  out  16  frames entering DROP, saturating.
REQ-018 stray_words  out  16  non-SOP words discarded in IDLE, saturating.

Function
REQ-019 Status encoding on all status ports: [7] SOP, [6] EOP, [5] ERR, [2:0] valid bytes in EOP word; other bits passed through unchanged.
REQ-020 eop_pending: +1 on rxhfifo_wen with wstatus[6]; -1 on a consumed read word with rstatus[6]; both in the same cycle gives no change; saturates at all-ones; never decrements below 0.
REQ-021 rxhfifo_ren = !rxhfifo_rempty && (!rxhfifo_ralmost_empty || eop_pending != 0) && !rxdfifo_walmost_full, registered-free combinational; 0 while reset is asserted.
REQ-022 rd_vld register = rxhfifo_ren delayed 1 cycle; each rd_vld cycle consumes exactly one word (rdata/rstatus).
REQ-023 Latency: a word read at cycle N appears on rxdfifo_wen/wdata/wstatus at N+2 when forwarded; rxdfifo_wen is high exactly 1 cycle per forwarded word.
REQ-024 FSM states IDLE, FRAME, DROP; reset state IDLE; transitions are evaluated only on rd_vld cycles.
REQ-025 IDLE, word with SOP and EOP: forward unchanged, frames_fwd +1, stay IDLE.
REQ-026 IDLE, word with SOP only: forward, word_cnt := 1, go to FRAME.
REQ-027 IDLE, word without SOP: discard, stray_words +1, stay IDLE.
REQ-028 FRAME, word with EOP and no SOP: forward, frames_fwd +1, go to IDLE.
REQ-029 FRAME, word with neither SOP nor EOP: forward, word_cnt +1.
REQ-030 FRAME, word with SOP (new start before EOP): forward with SOP cleared and EOP+ERR forced, [2:0] := 0, frames_drop +1. If the word also has EOP, go to IDLE; otherwise go to DROP.
REQ-031 FRAME, non-EOP word when word_cnt == MAX_FRAME_WORDS-1: forward with EOP+ERR forced, frames_drop +1, go to DROP.
REQ-032 DROP: discard every word; on a word with EOP, go to IDLE.
REQ-033 Counters saturate at 16'hFFFF.

Reset
REQ-034 Asserting reset_xgmii_rx at any time, including mid-frame, immediately forces: state IDLE; eop_pending, word_cnt, rd_vld 0; rxhfifo_ren, rxdfifo_wen 0; rxdfifo_wdata, rxdfifo_wstatus 0; all counters 0.
REQ-035 After deassertion, the first forwarded word is the next SOP word; the remainder of any partial frame is counted in stray_words.

Verification
REQ-036 Write a 3-word frame (SOP, mid, EOP with [2:0]=5) into a not-almost-empty hold FIFO -> 3 rxdfifo_wen pulses with data identical to the input, last status 8'h45, frames_fwd=1.
REQ-037 Write a 1-word frame while the FIFO is almost empty -> eop_pending=1 enables the read; word forwarded 2 cycles after ren; eop_pending returns to 0.
REQ-038 Hold rxdfifo_walmost_full=1 mid-frame for 10 cycles -> ren stays 0 and at most 2 words are written after assertion; resuming yields no loss and no duplication.
REQ-039 Feed SOP, mid, SOP, mid, EOP -> 3 words forwarded, the third with status EOP|ERR and SOP clear; frames_drop=1; the trailing 2 words are discarded and the state returns to IDLE.
REQ-040 Feed MAX_FRAME_WORDS+3 words with no EOP, then EOP -> MAX_FRAME_WORDS words forwarded, the last with EOP+ERR; remaining words dropped; then IDLE.
REQ-041 Assert reset during FRAME, then send 2 non-SOP words and a valid frame -> stray_words=2, and the new frame is forwarded intact.

Source files
------------

// File: rtl/rx_hold_drain_ctrl.sv
// Drains a hold FIFO into the downstream data FIFO, enforcing SOP/EOP framing,
// truncating over-long frames and discarding stray or broken frame remnants.
module rx_hold_drain_ctrl #(
  parameter int unsigned MAX_FRAME_WORDS = 1200,
  parameter int unsigned EOPC_WIDTH      = 4
) (
  input  logic        clk_xgmii_rx,
  input  logic        reset_xgmii_rx,
  input  logic        rxhfifo_wen,
  input  logic [7:0]  rxhfifo_wstatus,
  input  logic [63:0] rxhfifo_rdata,
  input  logic [7:0]  rxhfifo_rstatus,
  input  logic        rxhfifo_rempty,
  input  logic        rxhfifo_ralmost_empty,
  output logic        rxhfifo_ren,
  input  logic        rxdfifo_walmost_full,
  output logic        rxdfifo_wen,
  output logic [63:0] rxdfifo_wdata,
  output logic [7:0]  rxdfifo_wstatus,
  output logic [15:0] frames_fwd,
  output logic [15:0] frames_drop,
  output logic [15:0] stray_words
);

  localparam int unsigned SopBit = 7;
  localparam int unsigned EopBit = 6;
  localparam int unsigned WcW    = $clog2(MAX_FRAME_WORDS + 1);
  localparam logic [WcW-1:0] WcLast = WcW'(MAX_FRAME_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StFrame, StDrop} state_e;

  state_e                state_q, state_d;
  logic [WcW-1:0]        word_cnt_q, word_cnt_d;
  logic [EOPC_WIDTH-1:0] eop_pending_q, eop_pending_d;
  logic                  rd_vld_q;

  logic       eop_in, eop_out;
  logic       rd_sop, rd_eop;
  logic       fwd, fwd_inc, drop_inc, stray_inc;
  logic [7:0] fwd_status;

  // Only the EOP flag of the write side is of interest.
  logic unused_wstatus;
  assign unused_wstatus = ^{rxhfifo_wstatus[7], rxhfifo_wstatus[5:0]};

  assign rd_sop  = rxhfifo_rstatus[SopBit];
  assign rd_eop  = rxhfifo_rstatus[EopBit];
  assign eop_in  = rxhfifo_wen && rxhfifo_wstatus[EopBit];
  assign eop_out = rd_vld_q && rd_eop;

  // A complete frame waiting in the hold FIFO lets us read past almost-empty.
  assign rxhfifo_ren = !reset_xgmii_rx && !rxhfifo_rempty &&
                       (!rxhfifo_ralmost_empty || (eop_pending_q != '0)) &&
                       !rxdfifo_walmost_full;

  always_comb begin
    eop_pending_d = eop_pending_q;
    if (eop_in && !eop_out && (eop_pending_q != '1)) begin
      eop_pending_d = eop_pending_q + EOPC_WIDTH'(1);
    end else if (eop_out && !eop_in && (eop_pending_q != '0)) begin
      eop_pending_d = eop_pending_q - EOPC_WIDTH'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    fwd        = 1'b0;
    fwd_status = rxhfifo_rstatus;
    fwd_inc    = 1'b0;
    drop_inc   = 1'b0;
    stray_inc  = 1'b0;
    if (rd_vld_q) begin
      case (state_q)
        StIdle: begin
          if (rd_sop) begin
            fwd = 1'b1;
            if (rd_eop) begin
              fwd_inc = 1'b1;
            end else begin
              word_cnt_d = WcW'(1);
              state_d    = StFrame;
            end
          end else begin
            stray_inc = 1'b1;
          end
        end
        StFrame: begin
          fwd = 1'b1;
          if (rd_sop) begin
            // Restart before EOP: close the current frame as errored.
            fwd_status = {1'b0, 1'b1, 1'b1, rxhfifo_rstatus[4:3], 3'b000};
            drop_inc   = 1'b1;
            word_cnt_d = '0;
            state_d    = rd_eop ? StIdle : StDrop;
          end else if (rd_eop) begin
            fwd_inc    = 1'b1;
            word_cnt_d = '0;
            state_d    = StIdle;
          end else if (word_cnt_q == WcLast) begin
            fwd_status = rxhfifo_rstatus | 8'h60;
            drop_inc   = 1'b1;
            word_cnt_d = '0;
            state_d    = StDrop;
          end else begin
            word_cnt_d = word_cnt_q + WcW'(1);
          end
        end
        StDrop: begin
          if (rd_eop) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_xgmii_rx or posedge reset_xgmii_rx) begin
    if (reset_xgmii_rx) begin
      state_q       <= StIdle;
      word_cnt_q    <= '0;
      eop_pending_q <= '0;
      rd_vld_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      eop_pending_q <= eop_pending_d;
      rd_vld_q      <= rxhfifo_ren;
    end
  end

  always_ff @(posedge clk_xgmii_rx or posedge reset_xgmii_rx) begin
    if (reset_xgmii_rx) begin
      rxdfifo_wen     <= 1'b0;
      rxdfifo_wdata   <= '0;
      rxdfifo_wstatus <= '0;
    end else begin
      rxdfifo_wen <= fwd;
      if (fwd) begin
        rxdfifo_wdata   <= rxhfifo_rdata;
        rxdfifo_wstatus <= fwd_status;
      end
    end
  end

  always_ff @(posedge clk_xgmii_rx or posedge reset_xgmii_rx) begin
    if (reset_xgmii_rx) begin
      frames_fwd  <= '0;
      frames_drop <= '0;
      stray_words <= '0;
    end else begin
      if (fwd_inc && (frames_fwd != 16'hFFFF)) begin
        frames_fwd <= frames_fwd + 16'd1;
      end
      if (drop_inc && (frames_drop != 16'hFFFF)) begin
        frames_drop <= frames_drop + 16'd1;
      end
      if (stray_inc && (stray_words != 16'hFFFF)) begin
        stray_words <= stray_words + 16'd1;
      end
    end
  end

endmodule
